pc_fetch_ctrl: RTL and testbench

//  Owns the architectural PC register and sequences instruction fetch for the single-cycle core.

---
 rtl/pc_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer (BOOT -> REQ -> RESP -> HOLD) for the single-cycle core.
// Optional build macro: PC_MISALIGN_TRAP_EN redirects a misaligned next-PC to TRAP_PC.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module pc_fetch_ctrl #(
    parameter logic [`PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [`PC_WIDTH-1:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    output logic                 imem_req_o,
    output logic [`PC_WIDTH-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [31:0]          imem_rdata_i,
    output logic                 inst_valid_o,
    output logic [31:0]          inst_o,
    output logic [`PC_WIDTH-1:0] inst_pc_o,
    input  logic                 inst_ready_i,
    input  logic [`PC_WIDTH-1:0] pc_next_i,
    output logic [31:0]          retire_cnt_o,
    output logic                 misalign_o,
    output logic [1:0]           state_dbg_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t               state;
    logic [`PC_WIDTH-1:0] pc;
    logic                 misalign_q;

    // Handshakes: a fetch is accepted on the cycle imem_req_o && imem_gnt_i; the request
    // and address never change before acceptance. Data returns on imem_rvalid_i while in
    // RESP. A held instruction retires on the cycle inst_valid_o && inst_ready_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            inst_o       <= NOP;
            inst_pc_o    <= RESET_PC;
            inst_valid_o <= 1'b0;
            imem_req_o   <= 1'b0;
            retire_cnt_o <= 32'd0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                BOOT: begin
                    state      <= REQ;
                    imem_req_o <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt_i) begin
                        state      <= RESP;
                        imem_req_o <= 1'b0;
                    end
                end
                RESP: begin
                    if (imem_rvalid_i) begin
                        inst_o       <= imem_rdata_i;
                        inst_pc_o    <= pc;
                        inst_valid_o <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready_i) begin
                        retire_cnt_o <= retire_cnt_o + 32'd1;
                        inst_valid_o <= 1'b0;
                        imem_req_o   <= 1'b1;
                        state        <= REQ;
`ifdef PC_MISALIGN_TRAP_EN
                        if (pc_next_i[1:0] != 2'b00) begin
                            pc         <= TRAP_PC;
                            misalign_q <= 1'b1;
                        end else begin
                            pc <= pc_next_i;
                        end
`else
                        pc <= pc_next_i;
`endif
                    end
                end
                default: begin
                    state        <= BOOT;
                    imem_req_o   <= 1'b0;
                    inst_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr_o = pc;
    assign state_dbg_o = state;

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    // A pending request must hold its address until imem accepts it.
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (imem_req_o && !imem_gnt_i) |=> (imem_req_o && $stable(imem_addr_o)));

    // Both redirect targets must be word addresses.
    a_vectors_aligned: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (RESET_PC[1:0] == 2'b00) && (TRAP_PC[1:0] == 2'b00));

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: boot fetch, stalls, retire, counter wrap, reset abandon, misalign.

module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] pc_next;
    logic [31:0] retire_cnt;
    logic        misalign;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    pc_fetch_ctrl dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .inst_valid_o  (inst_valid),
        .inst_o        (inst),
        .inst_pc_o     (inst_pc),
        .inst_ready_i  (inst_ready),
        .pc_next_i     (pc_next),
        .retire_cnt_o  (retire_cnt),
        .misalign_o    (misalign),
        .state_dbg_o   (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // returns on the falling edge after the next rising edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_fetch(input string tag);
        logic [31:0] exp_addr;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: expected-address queue empty", tag);
        end else begin
            exp_addr = exp_q.pop_front();
            check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
            check({tag, "_addr"}, imem_addr, exp_addr);
        end
    endtask

    // drive one instruction from REQ (with immediate grant) into HOLD
    task automatic fetch_into_hold(input logic [31:0] word);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic retire(input logic [31:0] npc);
        inst_ready = 1'b1;
        pc_next    = npc;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        inst_ready  = 1'b0;
        pc_next     = 32'd0;

        // reset values
        tick();
        tick();
        check("rst_req",      {31'd0, imem_req}, 32'd0);
        check("rst_valid",    {31'd0, inst_valid}, 32'd0);
        check("rst_inst",     inst, 32'h0000_0013);
        check("rst_retire",   retire_cnt, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_addr",     imem_addr, 32'h0000_0000);

        // 1: boot fetch, grant immediately, rvalid next cycle
        rst_n    = 1'b1;
        imem_gnt = 1'b1;
        check("t1_boot_state", {30'd0, state_dbg}, {30'd0, S_BOOT});
        check("t1_boot_req",   {31'd0, imem_req}, 32'd0);
        tick();
        exp_q.push_back(32'h0000_0000);
        check_fetch("t1_c2");
        tick();
        imem_gnt    = 1'b0;
        check("t1_c3_state", {30'd0, state_dbg}, {30'd0, S_RESP});
        check("t1_c3_req",   {31'd0, imem_req}, 32'd0);
        check("t1_c3_valid", {31'd0, inst_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        check("t1_c4_valid",   {31'd0, inst_valid}, 32'd1);
        check("t1_c4_inst",    inst, 32'h0000_0013);
        check("t1_c4_inst_pc", inst_pc, 32'h0000_0000);

        // 3: hold without ready, then retire to 0x40
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_hold_valid", {31'd0, inst_valid}, 32'd1);
            check("t3_hold_state", {30'd0, state_dbg}, {30'd0, S_HOLD});
        end
        retire(32'h0000_0040);
        exp_q.push_back(32'h0000_0040);
        check_fetch("t3_next");
        check("t3_retire", retire_cnt, 32'd1);
        check("t3_valid",  {31'd0, inst_valid}, 32'd0);

        // 2: stall the grant for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_req",   {31'd0, imem_req}, 32'd1);
            check("t2_stall_addr",  imem_addr, 32'h0000_0040);
            check("t2_stall_state", {30'd0, state_dbg}, {30'd0, S_REQ});
        end
        fetch_into_hold(32'hDEAD_BEEF);
        check("t2_inst",    inst, 32'hDEAD_BEEF);
        check("t2_inst_pc", inst_pc, 32'h0000_0040);
        check("t2_valid",   {31'd0, inst_valid}, 32'd1);

        // 6: misaligned next-PC
        retire(32'h0000_0042);
`ifdef PC_MISALIGN_TRAP_EN
        exp_q.push_back(32'h0000_0100);
        check("t6_misalign", {31'd0, misalign}, 32'd1);
`else
        exp_q.push_back(32'h0000_0042);
        check("t6_misalign", {31'd0, misalign}, 32'd0);
`endif
        check_fetch("t6_next");
        check("t6_retire", retire_cnt, 32'd2);
        tick();
        check("t6_misalign_off", {31'd0, misalign}, 32'd0);

        // 4: counter wrap
        fetch_into_hold(32'h0010_0093);
        force dut.retire_cnt_o = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_o;
        #1;
        check("t4_preload", retire_cnt, 32'hFFFF_FFFF);
        retire(32'h0000_0008);
        check("t4_wrap", retire_cnt, 32'd0);
        exp_q.push_back(32'h0000_0008);
        check_fetch("t4_next");

        // 5: reset during RESP, late rvalid after release
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("t5_in_resp", {30'd0, state_dbg}, {30'd0, S_RESP});
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("t5_rst_addr",  imem_addr, 32'h0000_0000);
        tick();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        check("t5_valid", {31'd0, inst_valid}, 32'd0);
        check("t5_inst",  inst, 32'h0000_0013);
        exp_q.push_back(32'h0000_0000);
        check_fetch("t5_refetch");
        tick();
        imem_rvalid = 1'b0;
        check("t5_still_req", {30'd0, state_dbg}, {30'd0, S_REQ});
        fetch_into_hold(32'h0020_0113);
        check("t5_inst_new", inst, 32'h0020_0113);
        check("t5_inst_pc",  inst_pc, 32'h0000_0000);
        check("t5_retire",   retire_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
